// File: rtl/cache_port_scheduler.sv
// Round-robin arbiter sharing one cache port among N requesters.
// Ports: req_* (requester side), mem_* (cache port), rsp_* (return), busy, grant_id.
module cache_port_scheduler #(
   parameter int N         = 4,
   parameter int ADDR_BITS = 8,
   parameter int DATA_BITS = 16
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic [N-1:0]              req_valid,
   input  logic [N-1:0]              req_write,
   input  logic [N*ADDR_BITS-1:0]    req_addr,
   input  logic [N*DATA_BITS-1:0]    req_wdata,
   output logic [N-1:0]              req_ready,
   output logic [N-1:0]              rsp_valid,
   output logic [DATA_BITS-1:0]      rsp_data,
   output logic                      mem_req_valid,
   input  logic                      mem_req_ready,
   output logic                      mem_req_write,
   output logic [ADDR_BITS-1:0]      mem_req_addr,
   output logic [DATA_BITS-1:0]      mem_req_wdata,
   input  logic                      mem_rsp_valid,
   input  logic [DATA_BITS-1:0]      mem_rsp_data,
   output logic                      busy,
   output logic [$clog2(N)-1:0]      grant_id
);

   localparam int GW = $clog2(N);

   localparam logic [1:0] S_IDLE    = 2'd0;
   localparam logic [1:0] S_ISSUE   = 2'd1;
   localparam logic [1:0] S_WAIT    = 2'd2;
   localparam logic [1:0] S_RESPOND = 2'd3;

   logic [1:0]           r_state;
   logic [GW-1:0]        r_last_grant;
   logic [GW-1:0]        r_grant_id;
   logic                 r_write;
   logic [ADDR_BITS-1:0] r_addr;
   logic [DATA_BITS-1:0] r_wdata;
   logic [DATA_BITS-1:0] r_rsp_data;

   logic                 w_any;
   logic [GW-1:0]        w_sel;
   logic [N-1:0]         w_one;

   assign w_one = {{(N-1){1'b0}}, 1'b1};

   // Walk offsets from far to near so the nearest set bit after
   // last_grant is the one left standing.
   always_comb begin
      w_any = 1'b0;
      w_sel = '0;
      for (int k = N; k >= 1; k--) begin
         logic [GW-1:0] v_idx;
         v_idx = GW'((int'(r_last_grant) + k) % N);
         if (req_valid[v_idx]) begin
            w_any = 1'b1;
            w_sel = v_idx;
         end
      end
   end

   // Accept is suppressed while reset is held so nothing is granted
   // against a state that is being cleared.
   assign req_ready = (reset && r_state == S_IDLE && w_any)
                      ? (w_one << w_sel) : '0;
   assign rsp_valid = (r_state == S_RESPOND)
                      ? (w_one << r_grant_id) : '0;

   assign mem_req_valid = (r_state == S_ISSUE);
   assign mem_req_write = r_write;
   assign mem_req_addr  = r_addr;
   assign mem_req_wdata = r_wdata;
   assign rsp_data      = r_rsp_data;
   assign busy          = (r_state != S_IDLE);
   assign grant_id      = r_grant_id;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state      <= S_IDLE;
         r_last_grant <= GW'(N - 1);
         r_grant_id   <= '0;
         r_write      <= 1'b0;
         r_addr       <= '0;
         r_wdata      <= '0;
         r_rsp_data   <= '0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (w_any) begin
                  r_grant_id <= w_sel;
                  r_write    <= req_write[w_sel];
                  r_addr     <= req_addr[int'(w_sel)*ADDR_BITS +: ADDR_BITS];
                  r_wdata    <= req_wdata[int'(w_sel)*DATA_BITS +: DATA_BITS];
                  r_state    <= S_ISSUE;
               end
            end
            S_ISSUE: begin
               if (mem_req_ready) r_state <= S_WAIT;
            end
            S_WAIT: begin
               if (mem_rsp_valid) begin
                  r_rsp_data <= mem_rsp_data;
                  r_state    <= S_RESPOND;
               end
            end
            S_RESPOND: begin
               r_last_grant <= r_grant_id;
               r_state      <= S_IDLE;
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_cache_port_scheduler.sv
// Directed scoreboard bench for cache_port_scheduler.
// Expected (requester, data) pushed at accept, popped at rsp_valid.
module tb_cache_port_scheduler;

   localparam int N  = 4;
   localparam int AB = 8;
   localparam int DB = 16;

   logic          clk = 1'b0;
   logic          reset;
   logic [N-1:0]  req_valid;
   logic [N-1:0]  req_write;
   logic [N*AB-1:0] req_addr;
   logic [N*DB-1:0] req_wdata;
   logic [N-1:0]  req_ready;
   logic [N-1:0]  rsp_valid;
   logic [DB-1:0] rsp_data;
   logic          mem_req_valid;
   logic          mem_req_ready;
   logic          mem_req_write;
   logic [AB-1:0] mem_req_addr;
   logic [DB-1:0] mem_req_wdata;
   logic          mem_rsp_valid;
   logic [DB-1:0] mem_rsp_data;
   logic          busy;
   logic [1:0]    grant_id;

   typedef struct {
      int          id;
      logic [15:0] data;
   } exp_t;

   exp_t        sbq[$];
   logic [7:0]  addr_tab[N];
   logic [15:0] wd_tab[N];
   logic        wr_tab[N];
   int          n_assert = 0;
   int          n_fail   = 0;

   cache_port_scheduler #(.N(N), .ADDR_BITS(AB), .DATA_BITS(DB)) dut (
      .clk           (clk),
      .reset         (reset),
      .req_valid     (req_valid),
      .req_write     (req_write),
      .req_addr      (req_addr),
      .req_wdata     (req_wdata),
      .req_ready     (req_ready),
      .rsp_valid     (rsp_valid),
      .rsp_data      (rsp_data),
      .mem_req_valid (mem_req_valid),
      .mem_req_ready (mem_req_ready),
      .mem_req_write (mem_req_write),
      .mem_req_addr  (mem_req_addr),
      .mem_req_wdata (mem_req_wdata),
      .mem_rsp_valid (mem_rsp_valid),
      .mem_rsp_data  (mem_rsp_data),
      .busy          (busy),
      .grant_id      (grant_id)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic drive_tab();
      for (int i = 0; i < N; i++) begin
         req_addr[i*AB +: AB]  = addr_tab[i];
         req_wdata[i*DB +: DB] = wd_tab[i];
         req_write[i]          = wr_tab[i];
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk_issue(input int id);
      chk("issue_valid", {31'd0, mem_req_valid}, 32'd1);
      chk("issue_addr", {24'd0, mem_req_addr}, {24'd0, addr_tab[id]});
      chk("issue_wdata", {16'd0, mem_req_wdata}, {16'd0, wd_tab[id]});
      chk("issue_write", {31'd0, mem_req_write}, {31'd0, wr_tab[id]});
      chk("issue_ready0", {28'd0, req_ready}, 32'd0);
      chk("issue_busy", {31'd0, busy}, 32'd1);
      chk("issue_gid", {30'd0, grant_id}, id);
   endtask

   // Entered just after a rising edge with the DUT in IDLE.
   task automatic run_txn(input int id, input int stall, input bit early,
                          input logic [15:0] rdata);
      exp_t e;
      mem_req_ready = (stall == 0);
      @(negedge clk);
      chk("accept", {28'd0, req_ready}, 32'd1 << id);
      chk("accept_busy", {31'd0, busy}, 32'd0);
      e.id   = id;
      e.data = rdata;
      sbq.push_back(e);
      tick();
      for (int s = 0; s < stall; s++) begin
         @(negedge clk);
         chk_issue(id);
         tick();
      end
      mem_req_ready = 1'b1;
      if (early) begin
         mem_rsp_valid = 1'b1;
         mem_rsp_data  = 16'hDEAD;
      end
      @(negedge clk);
      chk_issue(id);
      tick();
      mem_rsp_valid = 1'b1;
      mem_rsp_data  = rdata;
      @(negedge clk);
      chk("wait_memv", {31'd0, mem_req_valid}, 32'd0);
      chk("wait_rspv", {28'd0, rsp_valid}, 32'd0);
      chk("wait_busy", {31'd0, busy}, 32'd1);
      tick();
      mem_rsp_valid = 1'b0;
      mem_rsp_data  = 16'h5555;
      @(negedge clk);
      if (sbq.size() == 0) begin
         chk("sb_empty", 32'd0, 32'd1);
      end else begin
         e = sbq.pop_front();
         chk("rsp_valid", {28'd0, rsp_valid}, 32'd1 << e.id);
         chk("rsp_data", {16'd0, rsp_data}, {16'd0, e.data});
      end
      chk("rsp_ready0", {28'd0, req_ready}, 32'd0);
      tick();
   endtask

   initial begin
      reset         = 1'b0;
      req_valid     = '0;
      req_write     = '0;
      req_addr      = '0;
      req_wdata     = '0;
      mem_req_ready = 1'b1;
      mem_rsp_valid = 1'b0;
      mem_rsp_data  = '0;
      for (int i = 0; i < N; i++) begin
         addr_tab[i] = 8'h10 + 8'(i);
         wd_tab[i]   = 16'h1000 + 16'(i);
         wr_tab[i]   = i[0];
      end

      // reset values, with requests present during reset
      tick();
      req_valid = 4'b1111;
      @(negedge clk);
      chk("rst_ready", {28'd0, req_ready}, 32'd0);
      chk("rst_rspv", {28'd0, rsp_valid}, 32'd0);
      chk("rst_memv", {31'd0, mem_req_valid}, 32'd0);
      chk("rst_busy", {31'd0, busy}, 32'd0);
      chk("rst_gid", {30'd0, grant_id}, 32'd0);
      chk("rst_rdata", {16'd0, rsp_data}, 32'd0);
      chk("rst_addr", {24'd0, mem_req_addr}, 32'd0);
      chk("rst_wdata", {16'd0, mem_req_wdata}, 32'd0);
      chk("rst_write", {31'd0, mem_req_write}, 32'd0);
      req_valid = '0;
      tick();
      reset = 1'b1;
      @(negedge clk);
      chk("post_rst_busy", {31'd0, busy}, 32'd0);
      chk("post_rst_ready", {28'd0, req_ready}, 32'd0);
      tick();

      // all four requesting: 0,1,2,3,0 one every 4 cycles
      drive_tab();
      req_valid = 4'b1111;
      run_txn(0, 0, 1'b0, 16'hA000);
      run_txn(1, 0, 1'b0, 16'hA001);
      run_txn(2, 0, 1'b0, 16'hA002);
      run_txn(3, 0, 1'b0, 16'hA003);
      run_txn(0, 0, 1'b0, 16'hA004);

      // lone read from requester 2
      req_valid   = 4'b0100;
      addr_tab[2] = 8'h3C;
      wr_tab[2]   = 1'b0;
      drive_tab();
      run_txn(2, 0, 1'b0, 16'hBEEF);

      // five-cycle back-pressure on the cache port
      req_valid = 4'b0010;
      run_txn(1, 5, 1'b0, 16'h0123);

      // reach last_grant=3, then 1001 gives 0 then 3
      req_valid = 4'b1000;
      run_txn(3, 0, 1'b0, 16'h3333);
      req_valid = 4'b1001;
      run_txn(0, 0, 1'b0, 16'h4444);
      run_txn(3, 0, 1'b1, 16'h5678);
      req_valid = '0;

      // outputs hold; stray mem response in IDLE ignored
      mem_rsp_valid = 1'b1;
      mem_rsp_data  = 16'hFACE;
      @(negedge clk);
      chk("hold_addr", {24'd0, mem_req_addr}, {24'd0, addr_tab[3]});
      chk("hold_rdata", {16'd0, rsp_data}, 32'h5678);
      tick();
      mem_rsp_valid = 1'b0;
      @(negedge clk);
      chk("idle_rsp_busy", {31'd0, busy}, 32'd0);
      chk("idle_rsp_rspv", {28'd0, rsp_valid}, 32'd0);
      chk("idle_rsp_data", {16'd0, rsp_data}, 32'h5678);

      // requester withdraws before the edge: not granted
      tick();
      req_valid = 4'b0010;
      @(negedge clk);
      chk("drop_ready", {28'd0, req_ready}, 32'b0010);
      #2;
      req_valid = '0;
      tick();
      @(negedge clk);
      chk("drop_busy", {31'd0, busy}, 32'd0);
      chk("drop_memv", {31'd0, mem_req_valid}, 32'd0);

      // reset during WAIT_RSP, stale response afterwards
      tick();
      req_valid     = 4'b0010;
      mem_req_ready = 1'b1;
      @(negedge clk);
      chk("abort_accept", {28'd0, req_ready}, 32'b0010);
      tick();
      req_valid = '0;
      tick();
      @(negedge clk);
      chk("abort_wait_busy", {31'd0, busy}, 32'd1);
      reset = 1'b0;
      #1;
      chk("abort_busy", {31'd0, busy}, 32'd0);
      chk("abort_gid", {30'd0, grant_id}, 32'd0);
      tick();
      reset = 1'b1;
      mem_rsp_valid = 1'b1;
      mem_rsp_data  = 16'hBAD0;
      @(negedge clk);
      chk("stale_busy", {31'd0, busy}, 32'd0);
      tick();
      mem_rsp_valid = 1'b0;
      @(negedge clk);
      chk("stale_rspv", {28'd0, rsp_valid}, 32'd0);
      chk("stale_busy2", {31'd0, busy}, 32'd0);
      chk("stale_rdata", {16'd0, rsp_data}, 32'd0);
      tick();
      req_valid = 4'b1111;
      run_txn(0, 0, 1'b0, 16'h0F0F);
      req_valid = '0;

      chk("sb_drained", sbq.size(), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures",
               n_assert, n_fail);
      $finish;
   end

endmodule
